// File: rtl/wb_dsp_pkg.sv
// Shared definitions for the DSP job-control Wishbone slave: register map,
// ID value, Wishbone cycle-type encodings and the response FSM states.
package wb_dsp_pkg;

  // Word index within the 32-byte register window (adr[4:2])
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_SRC    = 3'd2;
  localparam logic [2:0] REG_DST    = 3'd3;
  localparam logic [2:0] REG_LEN    = 3'd4;
  localparam logic [2:0] REG_FIFO   = 3'd5;
  localparam logic [2:0] REG_IRQ    = 3'd6;
  localparam logic [2:0] REG_ID     = 3'd7;

  localparam logic [31:0] ID_VALUE = 32'h4453_5001;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_CONST   = 3'b001,
    CTI_INCR    = 3'b010,
    CTI_END     = 3'b111
  } cti_e;

  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } bte_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESP  = 2'd1,
    ST_BURST = 2'd2
  } resp_state_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++)
      if (sel[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/wb_dsp_fifo.sv
// Sample FIFO between the bus and the DSP core; push is dropped when full,
// pop is dropped when empty, head reads 0 while empty.
module wb_dsp_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_dsp_slave_regs.sv
// Wishbone B3 register slave for the DSP core: job registers, start pulse,
// done interrupt and a sample FIFO, with classic and incrementing bursts.
// Handshake: a beat is taken when cyc&stb is high at an edge while no
// response is asserted (or while a burst continues); exactly one of
// ack/err/rty answers it on the next cycle, for one cycle.
module wb_dsp_slave_regs
  import wb_dsp_pkg::*;
#(
  parameter int            dw         = 32,
  parameter int            aw         = 32,
  parameter logic [aw-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter int            FIFO_DEPTH = 4
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic [aw-1:0] wb_adr_i,
  input  logic [dw-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [dw-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o,
  output logic [dw-1:0] src_addr_o,
  output logic [dw-1:0] dst_addr_o,
  output logic [dw-1:0] length_o,
  output logic          start_o,
  output logic          irq_en_o,
  output logic          irq_o,
  input  logic          busy_i,
  input  logic          done_i,
  input  logic          fifo_rd_i,
  output logic [dw-1:0] fifo_dat_o,
  output logic          fifo_empty_o,
  output logic [1:0]    dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  resp_state_e    state;
  logic           irq_en, irq_stat, irq_en_nxt, irq_stat_nxt;
  logic           beat, take, hit, dec_err, dec_rty, do_write, fifo_full;
  logic [2:0]     word;
  logic [dw-1:0]  rd_data;
  logic [CW-1:0]  fifo_count;
  logic [2:0]     unused_bits;

  assign unused_bits = {wb_bte_i, ^wb_adr_i[1:0]};
  assign dbg_state   = state;
  assign irq_en_o    = irq_en;

  assign beat = wb_cyc_i & wb_stb_i;
  assign take = beat & ((state == ST_IDLE) | (state == ST_BURST));
  assign hit  = (wb_adr_i[aw-1:5] == BASE_ADDR[aw-1:5]);
  assign word = wb_adr_i[4:2];

  always_comb begin
    dec_err  = !hit
             || (wb_we_i && (word == REG_STATUS || word == REG_ID))
             || (word == REG_FIFO && wb_sel_i != 4'hF);
    dec_rty  = !dec_err && wb_we_i && word == REG_FIFO && fifo_full;
    do_write = take && wb_we_i && !dec_err && !dec_rty;
  end

  always_comb begin
    rd_data = '0;
    case (word)
      REG_CTRL:   rd_data[1] = irq_en;
      REG_STATUS: begin
        rd_data[0]   = busy_i;
        rd_data[1]   = fifo_empty_o;
        rd_data[2]   = fifo_full;
        rd_data[8:4] = 5'(fifo_count);
      end
      REG_SRC:    rd_data = src_addr_o;
      REG_DST:    rd_data = dst_addr_o;
      REG_LEN:    rd_data = length_o;
      REG_FIFO:   rd_data = fifo_dat_o;
      REG_IRQ:    rd_data[0] = irq_stat;
      default:    rd_data = dw'(ID_VALUE);
    endcase
  end

  // A done pulse wins over a simultaneous write-1-to-clear
  always_comb begin
    irq_en_nxt   = irq_en;
    irq_stat_nxt = irq_stat;
    if (do_write && word == REG_CTRL && wb_sel_i[0]) irq_en_nxt = wb_dat_i[1];
    if (do_write && word == REG_IRQ && wb_sel_i[0] && wb_dat_i[0]) irq_stat_nxt = 1'b0;
    if (done_i) irq_stat_nxt = 1'b1;
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst) begin
      state      <= ST_IDLE;
      wb_ack_o   <= 1'b0;
      wb_err_o   <= 1'b0;
      wb_rty_o   <= 1'b0;
      wb_dat_o   <= '0;
      src_addr_o <= '0;
      dst_addr_o <= '0;
      length_o   <= '0;
      start_o    <= 1'b0;
      irq_en     <= 1'b0;
      irq_stat   <= 1'b0;
      irq_o      <= 1'b0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_rty_o <= 1'b0;
      wb_dat_o <= '0;
      start_o  <= 1'b0;

      case (state)
        ST_IDLE:  if (beat) state <= (wb_cti_i == CTI_INCR) ? ST_BURST : ST_RESP;
        ST_RESP:  state <= ST_IDLE;
        ST_BURST: if (beat) state <= (wb_cti_i == CTI_INCR) ? ST_BURST : ST_RESP;
                  else      state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase

      if (take) begin
        wb_ack_o <= !dec_err && !dec_rty;
        wb_err_o <= dec_err;
        wb_rty_o <= dec_rty;
        if (!dec_err && !wb_we_i) wb_dat_o <= rd_data;
      end

      if (do_write) begin
        case (word)
          REG_CTRL: start_o    <= wb_sel_i[0] & wb_dat_i[0];
          REG_SRC:  src_addr_o <= byte_merge(src_addr_o, wb_dat_i, wb_sel_i);
          REG_DST:  dst_addr_o <= byte_merge(dst_addr_o, wb_dat_i, wb_sel_i);
          REG_LEN:  length_o   <= byte_merge(length_o, wb_dat_i, wb_sel_i);
          default:  ;
        endcase
      end

      irq_en   <= irq_en_nxt;
      irq_stat <= irq_stat_nxt;
      irq_o    <= irq_stat_nxt & irq_en_nxt;
    end
  end

  wb_dsp_fifo #(
    .DW    (dw),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (wb_clk),
    .rst_n     (wb_rst),
    .push      (do_write && word == REG_FIFO),
    .push_data (wb_dat_i),
    .pop       (fifo_rd_i),
    .head      (fifo_dat_o),
    .full      (fifo_full),
    .empty     (fifo_empty_o),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_wb_dsp_slave_regs.sv
// Bench for wb_dsp_slave_regs: reset, table of classic register accesses,
// FIFO fill/drain against an expected queue, burst read and interrupt cases.
module tb_wb_dsp_slave_regs;

  localparam logic [31:0] BASE  = 32'h4000_0040;
  localparam logic [2:0]  R_ACK = 3'b100;
  localparam logic [2:0]  R_ERR = 3'b010;
  localparam logic [2:0]  R_RTY = 3'b001;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
  logic [2:0]  wb_cti_i = '0;
  logic [1:0]  wb_bte_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o, wb_rty_o;
  logic [31:0] src_addr_o, dst_addr_o, length_o, fifo_dat_o;
  logic        start_o, irq_en_o, irq_o, fifo_empty_o;
  logic        busy_i = 1'b0, done_i = 1'b0, fifo_rd_i = 1'b0;
  logic [1:0]  dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  int          start_cnt = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [7:0]  off;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        busy;
    logic [2:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[18];

  always #5 wb_clk = ~wb_clk;

  always @(negedge wb_clk) if (start_o) start_cnt++;

  wb_dsp_slave_regs #(
    .dw(32), .aw(32), .BASE_ADDR(BASE), .FIFO_DEPTH(4)
  ) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
    .src_addr_o(src_addr_o), .dst_addr_o(dst_addr_o), .length_o(length_o),
    .start_o(start_o), .irq_en_o(irq_en_o), .irq_o(irq_o),
    .busy_i(busy_i), .done_i(done_i),
    .fifo_rd_i(fifo_rd_i), .fifo_dat_o(fifo_dat_o), .fifo_empty_o(fifo_empty_o),
    .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One classic beat; optional core pop coincident with the acceptance edge
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic pop,
                         output logic [2:0] resp, output logic [31:0] rdata, output int lat);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_cti_i = 3'b000;
    fifo_rd_i = pop;
    resp = '0; rdata = '0; lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge wb_clk); #1;
      fifo_rd_i = 1'b0;
      if (wb_ack_o | wb_err_o | wb_rty_o) begin
        resp = {wb_ack_o, wb_err_o, wb_rty_o};
        rdata = wb_dat_o;
        lat = i;
        break;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge wb_clk); #1;
    check("resp_one_cycle", {29'd0, wb_ack_o, wb_err_o, wb_rty_o}, 32'd0);
  endtask

  task automatic xfer_chk(input string name, input logic we, input logic [7:0] off,
                          input logic [31:0] dat, input logic pop,
                          input logic [2:0] exp_resp, input logic [31:0] exp_rdata);
    logic [2:0]  resp;
    logic [31:0] rdata;
    int          lat;
    wb_xfer(we, BASE + 32'(off), dat, 4'hF, pop, resp, rdata, lat);
    check({name, "_resp"}, 32'(resp), 32'(exp_resp));
    check({name, "_data"}, rdata, exp_rdata);
  endtask

  task automatic pop_chk(input string name);
    logic [31:0] e;
    e = exp_q.pop_front();
    check(name, fifo_dat_o, e);
    fifo_rd_i = 1'b1;
    @(posedge wb_clk); #1;
    fifo_rd_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  resp;
    logic [31:0] rdata;
    int          lat, k, first, last, model_cnt;
    logic [31:0] bexp[4];

    vecs[0]  = '{1'b1, 8'h08, 32'h1234_5678, 4'hF, 1'b0, R_ACK, 32'h0};
    vecs[1]  = '{1'b0, 8'h08, 32'h0,         4'hF, 1'b0, R_ACK, 32'h1234_5678};
    vecs[2]  = '{1'b1, 8'h10, 32'hFFFF_AAFF, 4'h2, 1'b0, R_ACK, 32'h0};
    vecs[3]  = '{1'b0, 8'h10, 32'h0,         4'hF, 1'b0, R_ACK, 32'h0000_AA00};
    vecs[4]  = '{1'b1, 8'h0C, 32'hA5A5_C3C3, 4'h5, 1'b0, R_ACK, 32'h0};
    vecs[5]  = '{1'b0, 8'h0C, 32'h0,         4'hF, 1'b0, R_ACK, 32'h00A5_00C3};
    vecs[6]  = '{1'b1, 8'h1C, 32'h0,         4'hF, 1'b0, R_ERR, 32'h0};
    vecs[7]  = '{1'b0, 8'h20, 32'h0,         4'hF, 1'b0, R_ERR, 32'h0};
    vecs[8]  = '{1'b1, 8'h04, 32'hFFFF_FFFF, 4'hF, 1'b0, R_ERR, 32'h0};
    vecs[9]  = '{1'b0, 8'h1C, 32'h0,         4'hF, 1'b0, R_ACK, 32'h4453_5001};
    vecs[10] = '{1'b0, 8'h04, 32'h0,         4'hF, 1'b1, R_ACK, 32'h0000_0003};
    vecs[11] = '{1'b0, 8'h14, 32'h0,         4'hF, 1'b0, R_ACK, 32'h0};
    vecs[12] = '{1'b0, 8'h14, 32'h0,         4'h3, 1'b0, R_ERR, 32'h0};
    vecs[13] = '{1'b1, 8'h00, 32'h0000_0002, 4'h1, 1'b0, R_ACK, 32'h0};
    vecs[14] = '{1'b0, 8'h00, 32'h0,         4'hF, 1'b0, R_ACK, 32'h0000_0002};
    vecs[15] = '{1'b0, 8'h18, 32'h0,         4'hF, 1'b0, R_ACK, 32'h0};
    vecs[16] = '{1'b1, 8'h14, 32'h0BAD_0BAD, 4'h7, 1'b0, R_ERR, 32'h0};
    vecs[17] = '{1'b0, 8'h04, 32'h0,         4'hF, 1'b0, R_ACK, 32'h0000_0002};

    // Reset held with a write beat presented; it must leave no trace
    wb_rst = 1'b0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = BASE + 32'h08; wb_dat_i = 32'hDEAD_BEEF; wb_sel_i = 4'hF;
    repeat (3) @(posedge wb_clk);
    #1;
    check("rst_resp", {29'd0, wb_ack_o, wb_err_o, wb_rty_o}, 32'd0);
    check("rst_dat_o", wb_dat_o, 32'h0);
    check("rst_src", src_addr_o, 32'h0);
    check("rst_start_irq", {30'd0, start_o, irq_o}, 32'd0);
    check("rst_fifo_empty", 32'(fifo_empty_o), 32'd1);
    wb_rst = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    repeat (2) begin
      @(posedge wb_clk); #1;
      check("post_rst_no_resp", {29'd0, wb_ack_o, wb_err_o, wb_rty_o}, 32'd0);
    end
    check("post_rst_src", src_addr_o, 32'h0);

    for (int i = 0; i < 18; i++) begin
      busy_i = vecs[i].busy;
      wb_xfer(vecs[i].we, BASE + 32'(vecs[i].off), vecs[i].dat, vecs[i].sel, 1'b0,
              resp, rdata, lat);
      check($sformatf("vec%0d_resp", i), 32'(resp), 32'(vecs[i].exp_resp));
      check($sformatf("vec%0d_data", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
    end
    busy_i = 1'b0;
    check("src_addr_o", src_addr_o, 32'h1234_5678);
    check("dst_addr_o", dst_addr_o, 32'h00A5_00C3);
    check("length_o", length_o, 32'h0000_AA00);
    check("irq_en_o", 32'(irq_en_o), 32'd1);

    // Start bit pulses once and reads back as 0
    start_cnt = 0;
    xfer_chk("ctrl_start", 1'b1, 8'h00, 32'h0000_0003, 1'b0, R_ACK, 32'h0);
    check("start_pulses", 32'(start_cnt), 32'd1);
    xfer_chk("ctrl_rd", 1'b0, 8'h00, 32'h0, 1'b0, R_ACK, 32'h0000_0002);

    // Fill FIFO past depth; model decides ack vs rty
    model_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      xfer_chk($sformatf("fill%0d", i), 1'b1, 8'h14, 32'h100 + 32'(i), 1'b0,
               (model_cnt < 4) ? R_ACK : R_RTY, 32'h0);
      if (model_cnt < 4) begin
        exp_q.push_back(32'h100 + 32'(i));
        model_cnt++;
      end
    end
    xfer_chk("status_full", 1'b0, 8'h04, 32'h0, 1'b0, R_ACK, 32'h0000_0044);
    pop_chk("pop_head0");
    xfer_chk("fifo_peek", 1'b0, 8'h14, 32'h0, 1'b0, R_ACK, exp_q[0]);
    xfer_chk("push_after_pop", 1'b1, 8'h14, 32'h200, 1'b0, R_ACK, 32'h0);
    exp_q.push_back(32'h200);
    xfer_chk("status_full2", 1'b0, 8'h04, 32'h0, 1'b0, R_ACK, 32'h0000_0044);
    while (exp_q.size() > 0) pop_chk("drain");
    check("drained_empty", 32'(fifo_empty_o), 32'd1);
    fifo_rd_i = 1'b1;
    @(posedge wb_clk); #1;
    fifo_rd_i = 1'b0;
    xfer_chk("status_underflow", 1'b0, 8'h04, 32'h0, 1'b0, R_ACK, 32'h0000_0002);

    // Push+pop together, first when full then when not full
    for (int i = 0; i < 4; i++) begin
      xfer_chk("refill", 1'b1, 8'h14, 32'h400 + 32'(i), 1'b0, R_ACK, 32'h0);
      exp_q.push_back(32'h400 + 32'(i));
    end
    xfer_chk("full_push_pop", 1'b1, 8'h14, 32'h300, 1'b1, R_RTY, 32'h0);
    void'(exp_q.pop_front());
    xfer_chk("status_3a", 1'b0, 8'h04, 32'h0, 1'b0, R_ACK, 32'h0000_0030);
    xfer_chk("push_pop", 1'b1, 8'h14, 32'h500, 1'b1, R_ACK, 32'h0);
    void'(exp_q.pop_front());
    exp_q.push_back(32'h500);
    xfer_chk("status_3b", 1'b0, 8'h04, 32'h0, 1'b0, R_ACK, 32'h0000_0030);
    check("fifo_head", fifo_dat_o, exp_q[0]);

    // Incrementing burst over SRC, DST, LEN, FIFO_DATA
    bexp[0] = 32'h1234_5678;
    bexp[1] = 32'h00A5_00C3;
    bexp[2] = 32'h0000_AA00;
    bexp[3] = exp_q[0];
    k = 0; first = -1; last = -1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_sel_i = 4'hF;
    wb_adr_i = BASE + 32'h08; wb_cti_i = 3'b010;
    for (int c = 0; c < 12 && k < 4; c++) begin
      @(posedge wb_clk); #1;
      if (wb_ack_o) begin
        check($sformatf("burst%0d_data", k), wb_dat_o, bexp[k]);
        if (first < 0) first = c;
        last = c;
        k++;
        if (k < 4) begin
          wb_adr_i = BASE + 32'(8 + 4 * k);
          wb_cti_i = (k == 3) ? 3'b111 : 3'b010;
        end else begin
          wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        end
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = 3'b000;
    check("burst_beats", 32'(k), 32'd4);
    check("burst_span", 32'(last - first), 32'd3);
    @(posedge wb_clk); #1;
    check("burst_ack_low", 32'(wb_ack_o), 32'd0);
    @(posedge wb_clk); #1;

    // Interrupt: done alone, then done coincident with W1C, then W1C alone
    done_i = 1'b1;
    @(posedge wb_clk); #1;
    done_i = 1'b0;
    @(posedge wb_clk); #1;
    check("irq_after_done", 32'(irq_o), 32'd1);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = BASE + 32'h18; wb_dat_i = 32'h1; wb_sel_i = 4'hF;
    done_i = 1'b1;
    @(posedge wb_clk); #1;
    done_i = 1'b0;
    check("w1c_done_ack", 32'(wb_ack_o), 32'd1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge wb_clk); #1;
    check("irq_set_wins", 32'(irq_o), 32'd1);
    xfer_chk("irq_stat_set", 1'b0, 8'h18, 32'h0, 1'b0, R_ACK, 32'h1);
    xfer_chk("irq_w1c", 1'b1, 8'h18, 32'h1, 1'b0, R_ACK, 32'h0);
    check("irq_cleared", 32'(irq_o), 32'd0);
    xfer_chk("irq_stat_clr", 1'b0, 8'h18, 32'h0, 1'b0, R_ACK, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
